// File: rtl/vga_color_scheduler_if.sv
// Bundle of the v_sync / request / colour signals between the VGA source
// arbiter and its clients; the scheduler takes the slave side.
interface vga_color_scheduler_if;
    logic       v_sync;
    logic [2:0] req;
    logic [2:0] color0;
    logic [2:0] color1;
    logic [2:0] color2;
    logic [2:0] ctrl_rgb;
    logic [2:0] grant;
    logic       frame_tick;
    logic       busy;

    modport master (
        output v_sync, req, color0, color1, color2,
        input  ctrl_rgb, grant, frame_tick, busy
    );

    modport slave (
        input  v_sync, req, color0, color1, color2,
        output ctrl_rgb, grant, frame_tick, busy
    );
endinterface

// File: rtl/vga_color_scheduler.sv
// Frame-rate round-robin arbiter: picks one of three colour sources at each
// v_sync start and holds it for HOLD_FRAMES frames while it keeps requesting.
module vga_color_scheduler #(
    parameter int unsigned HOLD_FRAMES      = 4,
    parameter logic [2:0]  DEFAULT_RGB      = 3'b000,
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    vga_color_scheduler_if.slave  io_sched
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [7:0] CNT_LOAD = 8'(HOLD_FRAMES - 1);

    state_t     r_state, w_state_nxt;
    logic       r_vs_act_q;
    logic       w_vs_act, w_edge;
    logic [2:0] r_grant, w_grant_nxt;
    logic [2:0] r_rgb, w_rgb_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [1:0] r_last, w_last_nxt;
    logic [1:0] w_start, w_win_idx;
    logic       w_win_vld, w_rearb;
    logic       r_tick, r_busy;
    logic [2:0] w_colors [3];

    function automatic logic [1:0] rr_idx(input logic [1:0] s, input int k);
        logic [2:0] t;
        t = {1'b0, s} + 3'(k);
        return (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
    endfunction

    assign w_vs_act    = VSYNC_ACTIVE_LOW ? ~io_sched.v_sync : io_sched.v_sync;
    assign w_edge      = w_vs_act & ~r_vs_act_q;
    assign w_colors[0] = io_sched.color0;
    assign w_colors[1] = io_sched.color1;
    assign w_colors[2] = io_sched.color2;
    assign w_start     = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;

    // Walk the search order backwards so the earliest requester overwrites.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (io_sched.req[rr_idx(w_start, k)]) begin
                w_win_vld = 1'b1;
                w_win_idx = rr_idx(w_start, k);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rgb_nxt   = r_rgb;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_rearb     = 1'b0;
        if (w_edge) begin
            case (r_state)
                IDLE: w_rearb = (io_sched.req != 3'b000);
                HOLD: begin
                    if (!io_sched.req[r_last] || r_cnt == 8'd0) begin
                        w_rearb = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                        w_rgb_nxt = w_colors[r_last];
                    end
                end
                default: w_rearb = 1'b1;
            endcase
            if (w_rearb) begin
                if (w_win_vld) begin
                    w_state_nxt = HOLD;
                    w_grant_nxt = 3'b001 << w_win_idx;
                    w_rgb_nxt   = w_colors[w_win_idx];
                    w_cnt_nxt   = CNT_LOAD;
                    w_last_nxt  = w_win_idx;
                end else begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = 3'b000;
                    w_rgb_nxt   = DEFAULT_RGB;
                    w_cnt_nxt   = 8'd0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_vs_act_q <= 1'b0;
            r_grant    <= 3'b000;
            r_rgb      <= DEFAULT_RGB;
            r_cnt      <= 8'd0;
            r_last     <= 2'd2;
            r_tick     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_vs_act_q <= w_vs_act;
            r_grant    <= w_grant_nxt;
            r_rgb      <= w_rgb_nxt;
            r_cnt      <= w_cnt_nxt;
            r_last     <= w_last_nxt;
            r_tick     <= w_edge;
            r_busy     <= (w_grant_nxt != 3'b000);
        end
    end

    assign io_sched.ctrl_rgb   = r_rgb;
    assign io_sched.grant      = r_grant;
    assign io_sched.frame_tick = r_tick;
    assign io_sched.busy       = r_busy;

endmodule

// File: tb/tb_vga_color_scheduler.sv
// Scoreboard bench: each v_sync fall pushes the expected post-frame outputs;
// a monitor pops and compares on every frame_tick.
module tb_vga_color_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   ticks  = 0;
    int   pushes = 0;
    logic prev_tick = 1'b0;

    typedef struct packed {
        logic [2:0] grant;
        logic [2:0] rgb;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];

    vga_color_scheduler_if sif ();

    vga_color_scheduler #(
        .HOLD_FRAMES      (2),
        .DEFAULT_RGB      (3'b000),
        .VSYNC_ACTIVE_LOW (1'b1)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .io_sched (sif)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
        end
    endtask

    // Monitor: compare on every presented frame_tick.
    always @(negedge clk) begin
        if (!rst) begin
            if (sif.frame_tick) begin
                exp_t e;
                ticks++;
                chk("tick_not_back_to_back", 8'(prev_tick), 8'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_tick", 8'd1, 8'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant", 8'(sif.grant), 8'(e.grant));
                    chk("ctrl_rgb", 8'(sif.ctrl_rgb), 8'(e.rgb));
                    chk("busy", 8'(sif.busy), 8'(e.busy));
                end
            end
            prev_tick = sif.frame_tick;
        end else begin
            prev_tick = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_frame(input logic [2:0] g, input logic [2:0] c, input logic b);
        exp_q.push_back('{grant: g, rgb: c, busy: b});
        pushes++;
    endtask

    // One frame: v_sync low for a few cycles, then high again.
    task automatic vfall(input int low_cycles);
        sif.v_sync = 1'b0;
        cyc(low_cycles);
        sif.v_sync = 1'b1;
        cyc(5);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        #6;
        chk("rst_grant", 8'(sif.grant), 8'h0);
        chk("rst_rgb", 8'(sif.ctrl_rgb), 8'h0);
        chk("rst_busy", 8'(sif.busy), 8'h0);
        chk("rst_tick", 8'(sif.frame_tick), 8'h0);
        cyc(1);
    endtask

    initial begin
        sif.v_sync = 1'b1;
        sif.req    = 3'b000;
        sif.color0 = 3'b000;
        sif.color1 = 3'b000;
        sif.color2 = 3'b000;
        cyc(3);
        do_reset();

        // No requesters: stays idle, one tick per fall.
        for (int i = 0; i < 3; i++) begin
            expect_frame(3'b000, 3'b000, 1'b0);
            vfall(3);
        end

        // Single source; colour change mid-frame waits for the next fall.
        sif.req = 3'b001; sif.color0 = 3'b010;
        expect_frame(3'b001, 3'b010, 1'b1);
        vfall(3);
        sif.color0 = 3'b100;
        cyc(3);
        chk("midframe_rgb_hold", 8'(sif.ctrl_rgb), 8'(3'b010));
        expect_frame(3'b001, 3'b100, 1'b1);
        vfall(3);

        // Full round-robin with HOLD_FRAMES=2.
        do_reset();
        sif.req = 3'b111; sif.color0 = 3'b001; sif.color1 = 3'b010; sif.color2 = 3'b100;
        expect_frame(3'b001, 3'b001, 1'b1); vfall(3);
        expect_frame(3'b001, 3'b001, 1'b1); vfall(3);
        expect_frame(3'b010, 3'b010, 1'b1); vfall(3);
        expect_frame(3'b010, 3'b010, 1'b1); vfall(3);
        expect_frame(3'b100, 3'b100, 1'b1); vfall(3);
        expect_frame(3'b100, 3'b100, 1'b1); vfall(3);
        expect_frame(3'b001, 3'b001, 1'b1); vfall(3);

        // Owner 0 drops mid-hold: source 1 wins, counter reloaded.
        sif.req = 3'b110;
        expect_frame(3'b010, 3'b010, 1'b1); vfall(3);
        expect_frame(3'b010, 3'b010, 1'b1); vfall(3);
        expect_frame(3'b100, 3'b100, 1'b1); vfall(3);

        // Reset pulse while source 2 owns.
        sif.req = 3'b111;
        do_reset();
        expect_frame(3'b001, 3'b001, 1'b1); vfall(3);

        // v_sync held low ~5 frames: one tick only, later req change ignored.
        expect_frame(3'b001, 3'b001, 1'b1);
        sif.v_sync = 1'b0;
        cyc(4);
        sif.req = 3'b010; sif.color0 = 3'b111;
        cyc(40);
        sif.v_sync = 1'b1;
        cyc(3);
        chk("long_low_grant", 8'(sif.grant), 8'(3'b001));
        chk("long_low_rgb", 8'(sif.ctrl_rgb), 8'(3'b001));

        // Owner releases and nobody requests: back to idle default colour.
        sif.req = 3'b000;
        expect_frame(3'b000, 3'b000, 1'b0); vfall(3);

        cyc(5);
        chk("queue_drained", 8'(exp_q.size()), 8'd0);
        chk("tick_count", 8'(ticks), 8'(pushes));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_color_scheduler.md
VGA_COLOR_SCHEDULER -- requirements
Module: vga_color_scheduler

Interface
REQ-001 Parameter HOLD_FRAMES, default 4, SHALL set the number of frames a grant is held before rearbitration; legal range 1..255.
REQ-002 Parameter DEFAULT_RGB, default 3'b000, SHALL set the colour driven when no source is granted.
REQ-003 Parameter VSYNC_ACTIVE_LOW, default 1, SHALL set v_sync polarity (1 = active-low).
REQ-004 CLK  input  1  system clock (50 MHz); all logic SHALL be clocked on its rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 v_sync  input  1  vertical sync from Controlador_VGA, same clock domain.
REQ-007 req  input  3  per-source colour request; bit i = source i.
REQ-008 color0 / color1 / color2  input  3 each  requested RGB of source 0/1/2.
REQ-009 ctrl_rgb  output  3  colour to Controlador_VGA ctrl_rgb; registered.
REQ-010 grant  output  3  one-hot current owner, 3'b000 when idle; registered.
REQ-011 frame_tick  output  1  one-cycle pulse per frame start; registered.
REQ-012 busy  output  1  high while in HOLD; registered.

Function
REQ-013 The block SHALL register v_sync into v_sync_q each cycle; edge = (v_sync_q inactive) AND (v_sync active), per VSYNC_ACTIVE_LOW.
REQ-014 frame_tick SHALL be high exactly in the cycle after each edge cycle; never two consecutive cycles.
REQ-015 All arbitration, colour sampling and counter updates SHALL occur only in edge cycles; req/color changes between edges SHALL have no effect on any output.
REQ-016 The FSM SHALL have two states, IDLE and HOLD, encoded as the team's state register.
REQ-017 Round-robin: search order SHALL start at (last_owner+1) mod 3 and wrap; the first set req bit wins; a sole requester wins regardless of last_owner.
REQ-018 IDLE, edge, req != 0: grant winner, ctrl_rgb <= color of winner, hold counter <= HOLD_FRAMES-1, last_owner <= winner, go HOLD.
REQ-019 IDLE, edge, req == 0: remain IDLE, outputs unchanged.
REQ-020 HOLD, edge, owner's req bit low: rearbitrate per REQ-017 in the same edge cycle (owner's bit excluded since low).
REQ-021 HOLD, edge, owner's req high, counter == 0: rearbitrate per REQ-017; owner re-wins only if no other source requests.
REQ-022 HOLD, edge, owner's req high, counter != 0: counter decrements by 1, ctrl_rgb <= owner's current color (resampled once per frame), grant unchanged.
REQ-023 Any rearbitration with req == 0 SHALL go IDLE: grant <= 0, ctrl_rgb <= DEFAULT_RGB, busy <= 0.
REQ-024 Output updates SHALL be visible the cycle after the edge cycle, aligned with frame_tick.
REQ-025 grant SHALL always be one-hot or zero; busy SHALL equal (grant != 0).
REQ-026 Counter SHALL be 8 bits and SHALL never underflow; HOLD_FRAMES=1 forces rearbitration at every edge.

Reset
REQ-027 RESET high at a rising CLK edge SHALL set next cycle: state IDLE, grant 3'b000, ctrl_rgb DEFAULT_RGB, frame_tick 0, busy 0, counter 0, last_owner 2 (source 0 has first priority), v_sync_q inactive.
REQ-028 RESET SHALL override any simultaneous edge, mid-hold state included; the first edge after reset release SHALL be detectable.

Verification (HOLD_FRAMES=2, DEFAULT_RGB=000, active-low v_sync, 20 ns clock)
REQ-029 Reset then req=000, 3 v_sync falls -> grant=000, ctrl_rgb=000, busy=0; frame_tick pulses once per fall.
REQ-030 req=001, color0=010 -> after first fall grant=001, ctrl_rgb=010; color0 changed to 100 mid-frame -> ctrl_rgb stays 010 until next fall, then 100.
REQ-031 req=111, color0=001, color1=010, color2=100 -> grants 001,001,010,010,100,100,001 on consecutive falls; ctrl_rgb follows.
REQ-032 Owner 0 granted, req drops to 110 mid-hold -> next fall grant=010 (source 1), counter reloaded.
REQ-033 RESET pulsed 1 cycle while grant=100 -> next cycle grant=000, ctrl_rgb=000; with req=111 the next fall grants 001.
REQ-034 v_sync held low 5 frames' time (no rising edge) -> single frame_tick only, no grant change.
